// File: rtl/multiplier_pkg.sv
// Shared types for the shift-add multiplier datapath: controller strobe bundle
// and protocol-checker error-cause indices.
package multiplier_pkg;

  typedef struct packed {
    logic mdld;
    logic mrld;
    logic rsload;
    logic rsclear;
    logic rsshr;
  } ctrl_t;

  localparam int unsigned ERR_CAUSE_W        = 3;
  localparam int unsigned ERR_CLR_CONFLICT   = 0;
  localparam int unsigned ERR_LOAD_DURING_OP = 1;
  localparam int unsigned ERR_CARRY_LOST     = 2;

  // True when the running sum is being modified by an arithmetic strobe.
  function automatic logic rs_busy(input ctrl_t ctrl);
    return ctrl.rsload | ctrl.rsshr;
  endfunction

endpackage

// File: rtl/mult_dp_checker.sv
// Protocol checker for the multiplier datapath strobes; raises a sticky err
// on conflicting strobes or an add that would drop an unshifted carry.
module mult_dp_checker
  import multiplier_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  ctrl_t ctrl,
  input  logic  c,
  output logic  err
);

  logic [ERR_CAUSE_W-1:0] cause_c;

  always_comb begin
    cause_c                     = '0;
    cause_c[ERR_CLR_CONFLICT]   = ctrl.rsclear & rs_busy(ctrl);
    cause_c[ERR_LOAD_DURING_OP] = (ctrl.mdld | ctrl.mrld) & rs_busy(ctrl);
    cause_c[ERR_CARRY_LOST]     = ctrl.rsload & c;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (|cause_c) begin
      err <= 1'b1;
    end
  end

endmodule

// File: rtl/multiplier_datapath.sv
// Shift-add multiplier datapath: MD/MR/running-sum registers plus a product
// capture register with valid/ready handoff. Define MULT_DP_CHECK_EN to add the
// strobe protocol checker driving err.
module multiplier_datapath
  import multiplier_pkg::*;
#(
  parameter int unsigned WIDTH = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   md_in,
  input  logic [WIDTH-1:0]   mr_in,
  input  logic               mdld,
  input  logic               mrld,
  input  logic               rsload,
  input  logic               rsclear,
  input  logic               rsshr,
  input  logic               done,
  output logic [WIDTH-1:0]   mr,
  output logic [2*WIDTH-1:0] product,
  output logic [2*WIDTH-1:0] result,
  output logic               result_valid,
  input  logic               result_ready,
  output logic               overrun,
  output logic               err
);

  localparam int unsigned PW = 2 * WIDTH;

  logic [WIDTH-1:0] md_q;
  logic [WIDTH-1:0] mr_q;
  logic             rs_c;
  logic [WIDTH-1:0] rs_hi;
  logic [WIDTH-1:0] rs_lo;
  logic [PW-1:0]    result_q;
  logic             result_valid_q;
  logic             overrun_q;
  logic             done_d;

  logic [WIDTH:0]   sum_c;
  logic             capture_c;
  logic             consume_c;

  assign sum_c     = {1'b0, rs_hi} + {1'b0, md_q};
  assign capture_c = done & ~done_d;
  assign consume_c = result_valid_q & result_ready;

  // Operand registers; MR is never shifted, the controller indexes its bits.
  always_ff @(posedge clk) begin
    if (!rst) begin
      md_q <= '0;
      mr_q <= '0;
    end else begin
      if (mdld) md_q <= md_in;
      if (mrld) mr_q <= mr_in;
    end
  end

  // Running sum {c, hi, lo}; clear dominates, then fused add-shift.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rs_c  <= 1'b0;
      rs_hi <= '0;
      rs_lo <= '0;
    end else if (rsclear) begin
      rs_c  <= 1'b0;
      rs_hi <= '0;
      rs_lo <= '0;
    end else if (rsload && rsshr) begin
      rs_c  <= 1'b0;
      rs_hi <= sum_c[WIDTH:1];
      rs_lo <= {sum_c[0], rs_lo[WIDTH-1:1]};
    end else if (rsload) begin
      rs_c  <= sum_c[WIDTH];
      rs_hi <= sum_c[WIDTH-1:0];
    end else if (rsshr) begin
      rs_c  <= 1'b0;
      rs_hi <= {rs_c, rs_hi[WIDTH-1:1]};
      rs_lo <= {rs_hi[0], rs_lo[WIDTH-1:1]};
    end
  end

  // Product capture on the done rising edge with valid/ready handoff.
  always_ff @(posedge clk) begin
    if (!rst) begin
      done_d         <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      done_d <= done;
      if (capture_c) begin
        result_q       <= {rs_hi, rs_lo};
        result_valid_q <= 1'b1;
        if (result_valid_q && !result_ready) overrun_q <= 1'b1;
      end else if (consume_c) begin
        result_valid_q <= 1'b0;
      end
    end
  end

  assign mr           = mr_q;
  assign product      = {rs_hi, rs_lo};
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;

`ifdef MULT_DP_CHECK_EN
  ctrl_t ctrl_c;

  always_comb begin
    ctrl_c         = '0;
    ctrl_c.mdld    = mdld;
    ctrl_c.mrld    = mrld;
    ctrl_c.rsload  = rsload;
    ctrl_c.rsclear = rsclear;
    ctrl_c.rsshr   = rsshr;
  end

  mult_dp_checker u_checker (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ctrl_c),
    .c    (rs_c),
    .err  (err)
  );
`else
  assign err = 1'b0;
`endif

endmodule
